// File: rtl/uart_rx_module.sv
// 16x-oversampled UART receiver: 2-flop line sync, START/DATA/STOP FSM, done pulse and status.
// Define UART_RX_PARITY_EN to add a PARITY state (PARITY_ODD selects odd parity).
module uart_rx_module #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned SB_TICK     = 16,
  parameter int unsigned NB_TICK_CNT = 5
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD  = 1'b0
`endif
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_parity_err,
  output logic               o_busy
);

  localparam int unsigned NbBitCnt = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_TICK_CNT-1:0] TickMid  = NB_TICK_CNT'(7);
  localparam logic [NB_TICK_CNT-1:0] TickEnd  = NB_TICK_CNT'(15);
  localparam logic [NB_TICK_CNT-1:0] TickStop = NB_TICK_CNT'(SB_TICK - 1);
  localparam logic [NbBitCnt-1:0]    BitLast  = NbBitCnt'(NB_DATA - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

`ifdef UART_RX_PARITY_EN
  localparam state_e StAfterData = StParity;
`else
  localparam state_e StAfterData = StStop;
`endif

  logic                   rx_meta_q, rx_s_q;
  state_e                 state_q, state_d;
  logic [NB_TICK_CNT-1:0] s_q, s_d;
  logic [NbBitCnt-1:0]    n_q, n_d;
  logic [NB_DATA-1:0]     shreg_q, shreg_d;
  logic [NB_DATA-1:0]     data_q, data_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;
  logic                   stop_hit;

  // State register (all flops, synchronous reset)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; everything but the IDLE exit advances only on i_tick
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (i_tick) begin
          if (s_q == TickMid) begin
            s_d = '0;
            if (!rx_s_q) begin
              state_d = StData;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (i_tick) begin
          if (s_q == TickEnd) begin
            s_d     = '0;
            shreg_d = {rx_s_q, shreg_q[NB_DATA-1:1]};
            if (n_q == BitLast) begin
              state_d = StAfterData;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (i_tick) begin
          if (s_q == TickEnd) begin
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (i_tick) begin
          if (s_q == TickStop) begin
            s_d     = '0;
            state_d = StIdle;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign stop_hit = (state_q == StStop) && i_tick && (s_q == TickStop);

  // Output logic; busy is registered from state_d so it tracks state_q exactly
  always_comb begin
    done_d = stop_hit;
    data_d = data_q;
    ferr_d = ferr_q;
    busy_d = (state_d != StIdle);
    if (stop_hit) begin
      data_d = shreg_q;
      ferr_d = ~rx_s_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  always_comb begin
    par_d  = par_q;
    perr_d = perr_q;
    if ((state_q == StParity) && i_tick && (s_q == TickEnd)) begin
      par_d = (^shreg_q) ^ rx_s_q ^ PARITY_ODD;
    end
    if (stop_hit) begin
      perr_d = par_q;
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_module.sv
// Bench for uart_rx_module: serial frames at 64 clocks/bit (tick every 4 clocks), checked
// against a queue of expected words built from the bits the bench puts on the line.
module tb_uart_rx_module;

  localparam int BitClks = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;

  // Entries are {busy, parity_err, frame_err, data}
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];

  uart_rx_module dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_done    (o_rx_done),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge i_clk);
      tick_cnt++;
      i_tick = (tick_cnt % 4 == 0);
    end
  end

  // Every high sample of o_rx_done is one pulse; a stretched pulse shows up as an extra entry
  always @(negedge i_clk) begin
    if (o_rx_done) got_q.push_back({o_busy, o_parity_err, o_frame_err, o_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic line_hold(input logic v, input int clks);
    i_rx = v;
    repeat (clks) @(negedge i_clk);
  endtask

  // A bad stop bit is low through its sampling point, then the line returns high
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit bad_par);
    line_hold(1'b0, BitClks);
    for (int i = 0; i < 8; i++) line_hold(d[i], BitClks);
    if (ParEn) line_hold((^d) ^ bad_par, BitClks);
    if (stop_ok) begin
      line_hold(1'b1, BitClks);
    end else begin
      line_hold(1'b0, 40);
      line_hold(1'b1, BitClks - 40);
    end
    exp_q.push_back({1'b0, ParEn & bad_par, ~stop_ok, d});
  endtask

  task automatic check_frames(input string tag);
    logic [10:0] e, g;
    repeat (8) @(negedge i_clk);
    check_eq({tag, "_pulses"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check_eq({tag, "_data"}, 32'(g[7:0]), 32'(e[7:0]));
      check_eq({tag, "_ferr"}, 32'(g[8]), 32'(e[8]));
      check_eq({tag, "_perr"}, 32'(g[9]), 32'(e[9]));
      check_eq({tag, "_busy_at_done"}, 32'(g[10]), 32'(e[10]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, 32'(o_data), 32'h0);
    check_eq({tag, "_done"}, 32'(o_rx_done), 32'h0);
    check_eq({tag, "_ferr"}, 32'(o_frame_err), 32'h0);
    check_eq({tag, "_perr"}, 32'(o_parity_err), 32'h0);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'h0);
  endtask

  initial begin
    logic [7:0] d;
    bit         ok;
    bit         bp;
    int         gap;

    i_rx    = 1'b1;
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_reset = 1'b0;
    line_hold(1'b1, BitClks);
    check_reset_outputs("idle");

    send_frame(8'h55, 1'b1, 1'b0);
    check_frames("f55");
    check_eq("f55_busy_after", 32'(o_busy), 32'h0);

    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    check_frames("b2b");

    send_frame(8'h3C, 1'b0, 1'b0);
    line_hold(1'b1, BitClks);
    check_frames("ferr");
    check_eq("ferr_held", 32'(o_frame_err), 32'h1);
    send_frame(8'h81, 1'b1, 1'b0);
    check_frames("ferr_clear");

    // Short low glitch: false start, nothing delivered
    line_hold(1'b0, 20);
    line_hold(1'b1, 4 * BitClks);
    check_frames("glitch");
    check_eq("glitch_data_held", 32'(o_data), 32'h81);
    check_eq("glitch_busy", 32'(o_busy), 32'h0);

    // Reset in the middle of data bit 4 of 0xFF
    line_hold(1'b0, BitClks);
    for (int i = 0; i < 4; i++) line_hold(1'b1, BitClks);
    line_hold(1'b1, 20);
    check_eq("midframe_busy", 32'(o_busy), 32'h1);
    i_reset = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("midframe_rst");
    i_reset = 1'b0;
    line_hold(1'b1, 12 * BitClks);
    check_frames("rst_abort");
    send_frame(8'h12, 1'b1, 1'b0);
    check_frames("after_rst");

    if (ParEn) begin
      send_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1);
      check_frames("parity");
    end

    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      ok  = ($urandom_range(3) != 0);
      bp  = ParEn ? bit'($urandom_range(1)) : 1'b0;
      send_frame(d, ok, bp);
      gap = ok ? int'($urandom_range(2)) * (BitClks / 2) : BitClks + int'($urandom_range(16));
      if (gap > 0) line_hold(1'b1, gap);
    end
    line_hold(1'b1, BitClks);
    check_frames("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
